// File: rtl/qenc_pkg.sv
// Shared constants for the quadrature encoder sampler: controller state encoding and
// default data widths.
package qenc_pkg;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StZero = 2'd2;

    localparam int unsigned NbDefault = 32;
    localparam int unsigned PwDefault = 24;

endpackage

// File: rtl/qenc_period_timer.sv
// Sample-period down-counter: counts while enabled and pulses o_tick on the terminal
// cycle, reloading from the current period so a period of P yields one tick every P cycles.
module qenc_period_timer
    import qenc_pkg::*;
#(
    parameter int unsigned PW = PwDefault
) (
    input  logic          clk,
    input  logic          i_reset,
    input  logic          i_load,
    input  logic          i_en,
    input  logic [PW-1:0] i_period,
    output logic          o_tick
);

    logic [PW-1:0] timer_q, timer_d, reload;

    // A zero period behaves as one: tick every cycle.
    always_comb begin
        reload = (i_period == '0) ? '0 : i_period - PW'(1);
    end

    always_comb begin
        o_tick  = i_en && (timer_q == '0);
        timer_d = timer_q;
        if (i_load) begin
            timer_d = reload;
        end else if (i_en) begin
            timer_d = o_tick ? reload : timer_q - PW'(1);
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/qenc_sampler.sv
// Sequences an external quadrature encoder counter and emits periodic position/velocity
// samples on a valid/ready interface with a sticky overrun flag.
module qenc_sampler
    import qenc_pkg::*;
#(
    parameter int unsigned NB          = NbDefault,
    parameter int unsigned PW          = PwDefault,
    parameter int unsigned ZERO_CYCLES = 4
) (
    input  logic          clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic          i_zero,
    input  logic          i_clear_ovr,
    input  logic [PW-1:0] i_period,
    output logic          o_enc_enable,
    output logic          o_enc_reset_n,
    input  logic [NB-1:0] i_enc_position,
    input  logic          i_enc_dir,
    output logic [NB-1:0] o_sample_pos,
    output logic [NB-1:0] o_sample_delta,
    output logic          o_sample_dir,
    output logic          o_sample_valid,
    input  logic          i_sample_ready,
    output logic          o_overrun,
    output logic          o_running
);

    localparam int unsigned ZW = (ZERO_CYCLES > 1) ? $clog2(ZERO_CYCLES) : 1;

    logic [1:0]    state_q, state_d, ret_q, ret_d;
    logic [ZW-1:0] zcnt_q, zcnt_d;
    logic [NB-1:0] prev_q, prev_d, pos_q, pos_d, delta_q, delta_d;
    logic          dir_q, dir_d, valid_q, valid_d, ovr_q, ovr_d;
    logic          rstn_q;
    logic          timer_load, tick;

    qenc_period_timer #(
        .PW(PW)
    ) u_timer (
        .clk      (clk),
        .i_reset  (i_reset),
        .i_load   (timer_load),
        .i_en     (state_q == StRun),
        .i_period (i_period),
        .o_tick   (tick)
    );

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        zcnt_d     = zcnt_q;
        prev_d     = prev_q;
        pos_d      = pos_q;
        delta_d    = delta_q;
        dir_d      = dir_q;
        valid_d    = valid_q && !i_sample_ready;
        ovr_d      = ovr_q && !i_clear_ovr;
        timer_load = 1'b0;

        // Velocity history advances on every tick, even when the sample itself is dropped.
        if (tick) begin
            prev_d = i_enc_position;
            if (!valid_q || i_sample_ready) begin
                pos_d   = i_enc_position;
                delta_d = i_enc_position - prev_q;
                dir_d   = i_enc_dir;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (i_zero) begin
                    state_d = StZero;
                    ret_d   = StIdle;
                end else if (i_start) begin
                    state_d    = StRun;
                    prev_d     = i_enc_position;
                    timer_load = 1'b1;
                end
            end
            StRun: begin
                if (i_zero) begin
                    state_d = StZero;
                    ret_d   = StRun;
                end else if (i_stop) begin
                    state_d = StIdle;
                end
            end
            StZero: begin
                if (i_stop) begin
                    ret_d = StIdle;
                end
                if (zcnt_q == '0) begin
                    state_d    = ret_d;
                    timer_load = (ret_d == StRun);
                end else begin
                    zcnt_d = zcnt_q - ZW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Entering ZERO discards history and any pending sample without flagging overrun.
        if (state_d == StZero && state_q != StZero) begin
            zcnt_d  = ZW'(ZERO_CYCLES - 1);
            prev_d  = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
            ret_q   <= StIdle;
            zcnt_q  <= '0;
            prev_q  <= '0;
            pos_q   <= '0;
            delta_q <= '0;
            dir_q   <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            rstn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            zcnt_q  <= zcnt_d;
            prev_q  <= prev_d;
            pos_q   <= pos_d;
            delta_q <= delta_d;
            dir_q   <= dir_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            rstn_q  <= 1'b1;
        end
    end

    always_comb begin
        o_enc_enable   = (state_q == StRun);
        o_running      = (state_q == StRun);
        o_enc_reset_n  = rstn_q && (state_q != StZero);
        o_sample_pos   = pos_q;
        o_sample_delta = delta_q;
        o_sample_dir   = dir_q;
        o_sample_valid = valid_q;
        o_overrun      = ovr_q;
    end

endmodule

// File: tb/tb_qenc_sampler.sv
// Directed bench for qenc_sampler: the encoder position is driven as a ramp or fixed values
// and every expected sample is worked out by hand from the tick schedule.
module tb_qenc_sampler;

    logic        clk = 1'b0;
    logic        i_reset, i_start, i_stop, i_zero, i_clear_ovr;
    logic [23:0] i_period;
    logic        o_enc_enable, o_enc_reset_n;
    logic [31:0] pos;
    logic        dir;
    logic [31:0] o_sample_pos, o_sample_delta;
    logic        o_sample_dir, o_sample_valid, i_sample_ready, o_overrun, o_running;
    logic        ramp_en;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n;
    logic [31:0] a, b, e;

    always #5 clk = ~clk;

    qenc_sampler #(
        .NB(32),
        .PW(24),
        .ZERO_CYCLES(4)
    ) dut (
        .clk            (clk),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_stop         (i_stop),
        .i_zero         (i_zero),
        .i_clear_ovr    (i_clear_ovr),
        .i_period       (i_period),
        .o_enc_enable   (o_enc_enable),
        .o_enc_reset_n  (o_enc_reset_n),
        .i_enc_position (pos),
        .i_enc_dir      (dir),
        .o_sample_pos   (o_sample_pos),
        .o_sample_delta (o_sample_delta),
        .o_sample_dir   (o_sample_dir),
        .o_sample_valid (o_sample_valid),
        .i_sample_ready (i_sample_ready),
        .o_overrun      (o_overrun),
        .o_running      (o_running)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // One clock edge; the ramp advances just after the edge so the DUT saw the old value.
    task automatic step();
        @(posedge clk);
        #1;
        if (ramp_en) pos = pos + 32'd1;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!o_sample_valid && cnt < 50) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_zero = 1'b0; i_clear_ovr = 1'b0;
        i_period = 24'd0; pos = 32'd0; dir = 1'b0; i_sample_ready = 1'b1; ramp_en = 1'b0;
        #1;
        check("rst_enable", 32'(o_enc_enable), 32'd0);
        check("rst_enc_reset_n", 32'(o_enc_reset_n), 32'd0);
        check("rst_valid", 32'(o_sample_valid), 32'd0);
        check("rst_overrun", 32'(o_overrun), 32'd0);
        check("rst_running", 32'(o_running), 32'd0);
        check("rst_pos", o_sample_pos, 32'd0);
        step(); step();
        i_reset = 1'b0;
        step();
        check("post_rst_enc_reset_n", 32'(o_enc_reset_n), 32'd1);
        check("post_rst_idle_enable", 32'(o_enc_enable), 32'd0);

        // Period 10, ramp from 100
        i_period = 24'd10; pos = 32'd100; ramp_en = 1'b1; dir = 1'b1; i_start = 1'b1;
        step();
        i_start = 1'b0;
        check("run_running", 32'(o_running), 32'd1);
        check("run_enable", 32'(o_enc_enable), 32'd1);
        wait_valid(n);
        check("p10_first_latency", n, 32'd10);
        check("p10_first_pos", o_sample_pos, 32'd110);
        check("p10_first_delta", o_sample_delta, 32'd10);
        check("p10_first_dir", 32'(o_sample_dir), 32'd1);
        step();
        check("p10_valid_drop", 32'(o_sample_valid), 32'd0);
        wait_valid(n);
        check("p10_second_latency", n, 32'd9);
        check("p10_second_pos", o_sample_pos, 32'd120);
        check("p10_second_delta", o_sample_delta, 32'd10);

        // Stop, then period 0: a sample every cycle
        i_stop = 1'b1; step(); i_stop = 1'b0;
        check("stop_enable", 32'(o_enc_enable), 32'd0);
        check("stop_running", 32'(o_running), 32'd0);
        i_period = 24'd0; dir = 1'b0; i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e = pos;
            step();
            check("p0_valid", 32'(o_sample_valid), 32'd1);
            check("p0_pos", o_sample_pos, e);
            check("p0_delta", o_sample_delta, 32'd1);
        end
        check("p0_dir", 32'(o_sample_dir), 32'd0);

        // Overrun with ready low, period 3
        i_stop = 1'b1; step(); i_stop = 1'b0;
        step();
        check("drain_valid", 32'(o_sample_valid), 32'd0);
        i_period = 24'd3; i_sample_ready = 1'b0; i_start = 1'b1;
        step();
        i_start = 1'b0;
        step(); step();
        check("p3_no_early_tick", 32'(o_sample_valid), 32'd0);
        a = pos;
        step();
        check("p3_first_valid", 32'(o_sample_valid), 32'd1);
        check("p3_first_pos", o_sample_pos, a);
        check("p3_first_delta", o_sample_delta, 32'd3);
        step(); step(); step();
        check("ovr_set", 32'(o_overrun), 32'd1);
        check("ovr_held_pos", o_sample_pos, a);
        check("ovr_held_delta", o_sample_delta, 32'd3);
        i_clear_ovr = 1'b1; step(); i_clear_ovr = 1'b0;
        check("ovr_cleared", 32'(o_overrun), 32'd0);
        step();
        i_clear_ovr = 1'b1; step(); i_clear_ovr = 1'b0;
        check("ovr_set_beats_clear", 32'(o_overrun), 32'd1);
        check("ovr_still_held_pos", o_sample_pos, a);
        i_sample_ready = 1'b1;
        step();
        check("ovr_drain_valid", 32'(o_sample_valid), 32'd0);
        step();
        b = pos;
        step();
        check("after_drop_pos", o_sample_pos, b);
        check("after_drop_delta", o_sample_delta, 32'd3);
        i_clear_ovr = 1'b1; step(); i_clear_ovr = 1'b0;
        check("ovr_clear2", 32'(o_overrun), 32'd0);

        // Wrap-around deltas
        ramp_en = 1'b0; pos = 32'hFFFF_FFFE;
        step(); step();
        pos = 32'h0000_0003;
        step(); step(); step();
        check("wrap_up_pos", o_sample_pos, 32'h0000_0003);
        check("wrap_up_delta", o_sample_delta, 32'd5);
        pos = 32'd2;
        step(); step(); step();
        pos = 32'hFFFF_FFFD;
        step(); step(); step();
        check("wrap_down_pos", o_sample_pos, 32'hFFFF_FFFD);
        check("wrap_down_delta", o_sample_delta, 32'hFFFF_FFFB);

        // Zero while a sample is pending
        i_sample_ready = 1'b0; pos = 32'd7;
        i_zero = 1'b1; step(); i_zero = 1'b0;
        check("zero_enc_reset_n", 32'(o_enc_reset_n), 32'd0);
        check("zero_valid_cleared", 32'(o_sample_valid), 32'd0);
        check("zero_enable", 32'(o_enc_enable), 32'd0);
        check("zero_no_overrun", 32'(o_overrun), 32'd0);
        n = 1;
        while (o_enc_reset_n == 1'b0 && n < 20) begin
            step();
            if (o_enc_reset_n == 1'b0) n++;
        end
        check("zero_low_cycles", n, 32'd4);
        check("zero_back_to_run", 32'(o_running), 32'd1);
        wait_valid(n);
        check("zero_next_latency", n, 32'd3);
        check("zero_next_pos", o_sample_pos, 32'd7);
        check("zero_next_delta", o_sample_delta, 32'd7);

        // Stop keeps the pending sample; async reset mid-run clears everything
        i_stop = 1'b1; step(); i_stop = 1'b0;
        check("stop2_enable", 32'(o_enc_enable), 32'd0);
        check("stop2_valid_kept", 32'(o_sample_valid), 32'd1);
        check("stop2_pos_kept", o_sample_pos, 32'd7);
        i_period = 24'd1; dir = 1'b1; i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        check("p1_overrun", 32'(o_overrun), 32'd1);
        step();
        #2;
        i_reset = 1'b1;
        #1;
        check("arst_enable", 32'(o_enc_enable), 32'd0);
        check("arst_enc_reset_n", 32'(o_enc_reset_n), 32'd0);
        check("arst_valid", 32'(o_sample_valid), 32'd0);
        check("arst_pos", o_sample_pos, 32'd0);
        check("arst_delta", o_sample_delta, 32'd0);
        check("arst_overrun", 32'(o_overrun), 32'd0);
        check("arst_running", 32'(o_running), 32'd0);
        step();
        i_reset = 1'b0;
        step();
        check("arst_release_reset_n", 32'(o_enc_reset_n), 32'd1);
        check("arst_release_idle", 32'(o_running), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
